// File: rtl/reg_bank_reader.sv
// Bank of DEPTH x WIDTH registers with an enable-style write port and a
// valid/ready read port returning one-cycle-latency, backpressure-safe responses.
module reg_bank_reader #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CLR_ON_READ = 0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_rsp_valid,
  input  logic             rd_rsp_ready,
  output logic [WIDTH-1:0] rd_rsp_data
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             accept;
  logic             bypass;

  assign rd_req_ready = !rd_rsp_valid || rd_rsp_ready;
  assign accept       = rd_req_valid && rd_req_ready;
  assign bypass       = wr_en && (wr_addr == rd_addr);

  // Clear-on-read is issued before the write so a same-edge write wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if ((CLR_ON_READ != 0) && accept) regs[rd_addr] <= '0;
      if (wr_en) regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
    end else if (accept) begin
      rd_rsp_valid <= 1'b1;
      rd_rsp_data  <= bypass ? wr_data : regs[rd_addr];
    end else if (rd_rsp_ready) begin
      rd_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/reg_bank_reader.md
# reg_bank_reader

Parameterized bank of DEPTH registers, each WIDTH bits. A simple enable-style write port loads the registers. A valid/ready read port returns stored words with one cycle of latency and holds each response under backpressure. An optional clear-on-read mode supports status/sticky-flag registers. The block serves as the software/host-visible readback end of the parameterized register family, sitting between configuration/status logic and a bus adapter.

## Interface
- WIDTH, 8, data width of each register (≥1)
- DEPTH, 4, number of registers; power of two, ≥2
- CLR_ON_READ, 0, 1 = register at the read address is zeroed when its read request is accepted
- AW (derived, not overridable), $clog2(DEPTH), address width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- wr_en  input  1  write strobe
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data
- rd_req_valid  input  1  read request valid
- rd_req_ready  output  1  read request accepted when valid&&ready
- rd_addr  input  AW  read address, sampled on acceptance
- rd_rsp_valid  output  1  response valid
- rd_rsp_ready  input  1  downstream accepts response
- rd_rsp_data  output  WIDTH  response data

## Operation
- Reset (rst low, asynchronous): all registers become 0, rd_rsp_valid becomes 0, and rd_rsp_data becomes 0. rd_req_ready = 1 immediately, since it is combinational from the response state.
- Write: on each edge with wr_en=1, reg[wr_addr] <= wr_data. Writes are never stalled and do not interact with the read handshake.
- rd_req_ready = !rd_rsp_valid || rd_rsp_ready (combinational; a single response slot).
- Request accept (rd_req_valid && rd_req_ready) at edge N:
  - rd_rsp_data <= value of reg[rd_addr].
  - rd_rsp_valid <= 1.
- Read-during-write bypass: if the same edge has wr_en=1 and wr_addr==rd_addr, the response carries wr_data (write-first).
- Response pop (rd_rsp_valid && rd_rsp_ready) without a new accept: rd_rsp_valid <= 0, and rd_rsp_data holds its last value.
- Pop and accept on the same edge: the slot is reloaded with the new response and rd_rsp_valid stays 1. Back-to-back throughput is one read per cycle.
- Stall: while rd_rsp_valid=1 and rd_rsp_ready=0, rd_rsp_data and rd_rsp_valid hold stable. rd_req_ready=0.
- Stalled data is a snapshot: a later write to the same register does not alter a pending response.
- CLR_ON_READ=1: on accept, reg[rd_addr] <= 0 at the same edge. If a write to the same address occurs on that edge:
  - the write wins, and the register takes wr_data;
  - the response still returns wr_data via the bypass.
- CLR_ON_READ=0: reads have no side effect.
- rd_addr and wr_addr are always in range (DEPTH is a power of two); no error path exists.

## Timing
- Read latency: 1 cycle. Request accepted at edge N → rd_rsp_valid=1 with data after edge N.
- Write-to-read visibility:
  - write at edge N, read accepted at edge N+1 → returns the new value;
  - write and read accepted at the same edge N → also returns the new value (bypass).
- rd_req_ready depends combinationally on rd_rsp_ready only. There is no path from rd_req_valid to any output in the same cycle.
- Reset deassertion is synchronized externally. The block accepts requests on the first edge after rst rises.
- Reset asserted mid-transaction: a pending response is dropped (rd_rsp_valid→0 asynchronously), and all registers clear. A write on that edge is lost.

## Test plan
- Reset: write 0xA5 to addr 2, pulse rst low mid-cycle → rd_rsp_valid=0 and rd_rsp_data=0 immediately; then reading addr 2 returns 0x00.
- Basic write/read, DEPTH=4: write 0x11, 0x22, 0x33, 0x44 to addr 0–3, then read 3,0,2,1 back-to-back with rd_rsp_ready=1 → responses 0x44, 0x11, 0x33, 0x22 on consecutive cycles, each 1 cycle after acceptance, with rd_req_ready held at 1.
- Backpressure: with addr 1=0x22, accept a read of addr 1 and hold rd_rsp_ready=0 for 3 cycles while writing 0x99 to addr 1 → rd_req_ready=0, and rd_rsp_data stays 0x22 throughout. Release → pop, then a new read returns 0x99.
- Bypass: on one edge, write 0x5C to addr 3 and accept a read of addr 3 → response 0x5C.
- CLR_ON_READ=1: addr 0=0x0F; read addr 0 → 0x0F, then read addr 0 again → 0x00. Repeat with a same-edge write of 0x7E → both responses 0x7E, and the register keeps 0x7E.
- Simultaneous pop+accept: with a response pending and rd_rsp_ready=1 while a new request is valid → rd_rsp_valid stays 1 and the data switches to the new word on the next edge, with no bubble.
